// File: rtl/sign2reg.sv
// sign2reg: decodes a serial pulse train on flag_sign into a WIDTH-bit value.
// A frame is a burst of rising edges closed by GAP_CYC consecutive low
// samples. Value v is sent as v+1 pulses, and one frame yields one reg_valid
// strobe. Frames with more than 2**WIDTH pulses decode as all-ones and raise
// err_ovf together with the strobe.
module sign2reg #(
  parameter int WIDTH   = 3,
  parameter int GAP_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_sign,
  output logic [WIDTH-1:0] reg_sign,
  output logic             reg_valid,
  output logic             err_ovf,
  output logic             busy
);

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [WIDTH:0] PCNT_MAX = (WIDTH + 1)'(1) << WIDTH;
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t         state;
  logic           s1, s2, s3;
  logic [WIDTH:0] pcnt;
  logic [GW-1:0]  gcnt;
  logic           ovf;
  logic           rise;

  // A rising edge is a 0 in the delay stage followed by a 1 in the second
  // synchronizer stage.
  assign rise = s2 & ~s3;

  // Two-flop synchronizer for the asynchronous line, plus one delay stage for
  // edge detection.
  // NOTE: sequential state is updated with non-blocking assignments. Each
  // stage then samples the value its predecessor held before this edge, so
  // the chain stays a real shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= flag_sign;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Frame FSM. It counts pulses and low-gap cycles and drives all outputs
  // from registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      gcnt      <= '0;
      ovf       <= 1'b0;
      reg_sign  <= '0;
      reg_valid <= 1'b0;
      err_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // The strobes are high only on the closing cycle.
      reg_valid <= 1'b0;
      err_ovf   <= 1'b0;
      unique case (state)
        IDLE: begin
          // A level that is already high with no rising edge starts nothing.
          if (rise) begin
            state <= COUNT;
            pcnt  <= (WIDTH + 1)'(1);
            gcnt  <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        COUNT: begin
          if (rise) begin
            // A pulse arriving on what would be the closing cycle still
            // counts, and the frame goes on.
            gcnt <= '0;
            if (pcnt == PCNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              pcnt <= pcnt + (WIDTH + 1)'(1);
            end
          end else if (s2) begin
            // Only low time counts as gap, so a long high pulse never closes
            // the frame.
            gcnt <= '0;
          end else if (gcnt == GAP_LAST) begin
            // This is the GAP_CYC-th consecutive low sample, so deliver the
            // value.
            state     <= IDLE;
            busy      <= 1'b0;
            reg_valid <= 1'b1;
            err_ovf   <= ovf;
            reg_sign  <= ovf ? {WIDTH{1'b1}}
                             : WIDTH'(pcnt - (WIDTH + 1)'(1));
            gcnt      <= '0;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sign2reg.sv
// Testbench for sign2reg. Every frame is sent as a known number of pulses
// with random widths. The expected strobe (cycle, value, overflow) comes
// from the pulse count and from the time the line last fell.
module tb_sign2reg;

  localparam int WIDTH   = 3;
  localparam int GAP_CYC = 8;
  localparam int MAXP    = 1 << WIDTH;

  logic             clk;
  logic             rst;
  logic             flag_sign;
  logic [WIDTH-1:0] reg_sign;
  logic             reg_valid;
  logic             err_ovf;
  logic             busy;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int stray = 0;
  int last_fall = 0;

  typedef struct {
    int cyc;
    int val;
    bit ovf;
  } strobe_t;

  strobe_t obs_q[$];
  strobe_t exp_q[$];

  sign2reg #(.WIDTH(WIDTH), .GAP_CYC(GAP_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .flag_sign (flag_sign),
    .reg_sign  (reg_sign),
    .reg_valid (reg_valid),
    .err_ovf   (err_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_valid) begin
        strobe_t s;
        s.cyc = cyc;
        s.val = int'(reg_sign);
        s.ovf = err_ovf;
        obs_q.push_back(s);
      end else if (err_ovf) begin
        stray++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: n pulses decode to n-1, or to all-ones with overflow
  // when n exceeds 2**WIDTH. The strobe appears two synchronizer cycles plus
  // GAP_CYC cycles after the line last fell.
  task automatic expect_frame(input int n, input int fall);
    strobe_t s;
    s.cyc = fall + 2 + GAP_CYC;
    s.ovf = (n > MAXP);
    s.val = (n > MAXP) ? MAXP - 1 : n - 1;
    exp_q.push_back(s);
  endtask

  // Send n pulses. High time is random in [min_high, max_high] and in-frame
  // low time is random in [2, max_low]. After the last pulse the line is
  // held low for last_low cycles.
  task automatic send_pulses(input int n, input int min_high, input int max_high,
                             input int max_low, input int last_low);
    for (int i = 0; i < n; i++) begin
      flag_sign = 1'b1;
      repeat ($urandom_range(max_high, min_high)) tick();
      flag_sign = 1'b0;
      last_fall = cyc;
      if (i < n - 1) repeat ($urandom_range(max_low, 2)) tick();
      else repeat (last_low) tick();
    end
  endtask

  // Hold the line low long enough for any frame to close, then compare the
  // observed strobes against the expected ones.
  task automatic settle(input string name, input bit expect_busy);
    flag_sign = 1'b0;
    for (int i = 0; i < GAP_CYC + 8; i++) begin
      tick();
      if (i == 2) begin
        nchk++;
        if (busy !== expect_busy) begin
          nerr++;
          $display("FAIL %s busy mid-gap: got %b expected %b", name, busy, expect_busy);
        end
      end
    end
    nchk++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s busy after gap: got %b expected 0", name, busy);
    end
    nchk++;
    if (obs_q.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL %s strobe count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        nchk++;
        if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].val !== exp_q[i].val ||
            obs_q[i].ovf !== exp_q[i].ovf) begin
          nerr++;
          $display("FAIL %s strobe %0d: got cyc=%0d val=%0d ovf=%b expected cyc=%0d val=%0d ovf=%b",
                   name, i, obs_q[i].cyc, obs_q[i].val, obs_q[i].ovf,
                   exp_q[i].cyc, exp_q[i].val, exp_q[i].ovf);
        end
      end
      if (exp_q.size() > 0) begin
        nchk++;
        if (int'(reg_sign) !== exp_q[$].val) begin
          nerr++;
          $display("FAIL %s held reg_sign: got %0d expected %0d", name, reg_sign, exp_q[$].val);
        end
      end
    end
    nchk++;
    if (stray != 0) begin
      nerr++;
      $display("FAIL %s err_ovf without reg_valid: got %0d expected 0", name, stray);
    end
    obs_q.delete();
    exp_q.delete();
    stray = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flag_sign = 1'b0;
    repeat (10) begin
      tick();
      nchk++;
      if (reg_sign !== '0 || reg_valid !== 1'b0 || err_ovf !== 1'b0 || busy !== 1'b0) begin
        nerr++;
        $display("FAIL reset outputs: got sign=%0d valid=%b ovf=%b busy=%b expected 0 0 0 0",
                 reg_sign, reg_valid, err_ovf, busy);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_three_pulses();
    send_pulses(3, 2, 2, 2, 0);
    expect_frame(3, last_fall);
    settle("three_pulses", 1'b1);
  endtask

  task automatic test_bounds();
    send_pulses(1, 2, 2, 2, 0);
    expect_frame(1, last_fall);
    settle("one_pulse", 1'b1);
    send_pulses(MAXP, 2, 3, 3, 0);
    expect_frame(MAXP, last_fall);
    settle("max_pulses", 1'b1);
  endtask

  task automatic test_overflow();
    send_pulses(10, 2, 3, 3, 0);
    expect_frame(10, last_fall);
    settle("overflow", 1'b1);
  endtask

  task automatic test_inner_gap();
    send_pulses(5, 2, 3, 3, GAP_CYC - 1);
    send_pulses(2, 2, 3, 3, 0);
    expect_frame(7, last_fall);
    settle("inner_gap", 1'b1);
  endtask

  task automatic test_long_high();
    send_pulses(3, GAP_CYC + 2, GAP_CYC + 5, 4, 0);
    expect_frame(3, last_fall);
    settle("long_high", 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    send_pulses(2, 2, 3, 3, 2);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    nchk++;
    if (reg_sign !== '0) begin
      nerr++;
      $display("FAIL reset_mid_frame reg_sign: got %0d expected 0", reg_sign);
    end
    settle("reset_mid_frame", 1'b0);
    nchk++;
    if (reg_sign !== '0) begin
      nerr++;
      $display("FAIL reset_mid_frame held reg_sign: got %0d expected 0", reg_sign);
    end
    send_pulses(4, 2, 3, 3, 0);
    expect_frame(4, last_fall);
    settle("after_reset", 1'b1);
  endtask

  task automatic test_back_to_back();
    // The line stays low for exactly GAP_CYC cycles, so the next rise lands
    // in the cycle right after the close.
    send_pulses(3, 2, 3, 3, GAP_CYC);
    expect_frame(3, last_fall);
    send_pulses(2, 2, 3, 3, 0);
    expect_frame(2, last_fall);
    settle("back_to_back", 1'b1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(MAXP + 3, 1);
      send_pulses(n, 2, 5, GAP_CYC - 1, 0);
      expect_frame(n, last_fall);
      settle("random", 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    flag_sign = 1'b0;
    test_reset();
    test_three_pulses();
    test_bounds();
    test_overflow();
    test_inner_gap();
    test_long_high();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
